// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the MPU fetch path.
// Sequencer state encoding and opcode constants also used by the decoder.
package program_sequencer_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

    localparam logic [7:0] DEFAULT_PARK = 8'hC0;
    localparam logic [3:0] OP_JUMP      = 4'hE;
    localparam logic [3:0] OP_JUMP_NZ   = 4'hF;

endpackage

// File: rtl/program_sequencer_pm_ram.sv
// Program memory: byte array with synchronous write and asynchronous read.
// Contents are not reset so a program survives a sequencer reset.
module program_sequencer_pm_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [2**ADDR_W];

    // Loader write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/program_sequencer.sv
// Fetch sequencer: PC, branch steering with one delay slot, and byte loader.
// Instructions are parked while loading; PM is read combinationally in RUN.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter logic [7:0]  PARK_INSTR = DEFAULT_PARK
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              jmp,
    input  logic              jmp_nz,
    input  logic [3:0]        ir_nibble,
    input  logic              zero_flag,
    input  logic              prog_valid,
    input  logic [7:0]        prog_data,
    output logic              prog_ready,
    input  logic              run_start,
    input  logic              load_req,
    output logic [7:0]        next_instr,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic [ADDR_W-1:0] load_count
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] r_load_count;
    logic [ADDR_W-1:0] w_count_nxt;
    logic [ADDR_W-1:0] w_target;
    logic              w_take;
    logic              w_we;
    logic [7:0]        w_rdata;

    // Jump page comes from the delay-slot address already in the PC
    assign w_target = {r_pc[ADDR_W-1:4], ir_nibble};
    assign w_take   = jmp | (jmp_nz & ~zero_flag);

    // State, PC and loader address registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_LOAD;
            r_pc         <= '0;
            r_load_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_load_count <= w_count_nxt;
        end
    end

    // Next-state, next-PC and loader write decisions
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_count_nxt = r_load_count;
        w_we        = 1'b0;
        unique case (r_state)
            ST_LOAD: begin
                if (prog_valid) begin
                    w_we        = 1'b1;
                    w_count_nxt = r_load_count + ADDR_W'(1);
                end
                if (run_start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = '0;
                end
            end
            ST_RUN: begin
                if (load_req) begin
                    w_state_nxt = ST_LOAD;
                    w_pc_nxt    = '0;
                    w_count_nxt = '0;
                end else if (w_take) begin
                    w_pc_nxt = w_target;
                end else begin
                    w_pc_nxt = r_pc + ADDR_W'(1);
                end
            end
        endcase
    end

    program_sequencer_pm_ram #(
        .ADDR_W (ADDR_W)
    ) u_pm (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_load_count),
        .i_wdata (prog_data),
        .i_raddr (r_pc),
        .o_rdata (w_rdata)
    );

    assign running    = (r_state == ST_RUN);
    assign prog_ready = (r_state == ST_LOAD);
    assign next_instr = running ? w_rdata : PARK_INSTR;
    assign pc         = r_pc;
    assign load_count = r_load_count;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: behavioural model with per-cycle compare,
// directed fetch-order checks and randomized load/run traffic.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       zero_flag = 1'b0;
    logic       prog_valid = 1'b0;
    logic [7:0] prog_data = 8'h00;
    logic       run_start = 1'b0;
    logic       load_req = 1'b0;

    logic       ovr = 1'b0;
    logic       ovr_jmp = 1'b0;
    logic       ovr_nz = 1'b0;
    logic [3:0] ovr_nib = 4'h0;

    logic       jmp;
    logic       jmp_nz;
    logic [3:0] ir_nibble;
    logic       prog_ready;
    logic       running;
    logic [7:0] next_instr;
    logic [7:0] pc;
    logic [7:0] load_count;
    logic [7:0] ir;

    int checks = 0;
    int errors = 0;

    logic [7:0] img [256];
    int q[$];
    int qi[$];

    logic [7:0] m_pm [256];
    logic       m_run;
    int         m_pc;
    int         m_cnt;

    program_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .jmp        (jmp),
        .jmp_nz     (jmp_nz),
        .ir_nibble  (ir_nibble),
        .zero_flag  (zero_flag),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .run_start  (run_start),
        .load_req   (load_req),
        .next_instr (next_instr),
        .pc         (pc),
        .running    (running),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    // Decoder stand-in: registers next_instr and decodes jump opcodes
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ir <= 8'hC0;
        else          ir <= next_instr;
    end

    assign jmp       = ovr ? ovr_jmp : (ir[7:4] == 4'hE);
    assign jmp_nz    = ovr ? ovr_nz  : (ir[7:4] == 4'hF);
    assign ir_nibble = ovr ? ovr_nib : ir[3:0];

    // Reference model: two modes, a PM array and two counters
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run <= 1'b0;
            m_pc  <= 0;
            m_cnt <= 0;
        end else if (!m_run) begin
            if (prog_valid) begin
                m_pm[m_cnt] <= prog_data;
                m_cnt       <= (m_cnt + 1) % 256;
            end
            if (run_start) begin
                m_run <= 1'b1;
                m_pc  <= 0;
            end
        end else if (load_req) begin
            m_run <= 1'b0;
            m_pc  <= 0;
            m_cnt <= 0;
        end else if (jmp || (jmp_nz && !zero_flag)) begin
            m_pc <= (m_pc / 16) * 16 + int'(ir_nibble);
        end else begin
            m_pc <= (m_pc + 1) % 256;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model
    always @(negedge clk) begin
        chk("pc", int'(pc), m_pc);
        chk("load_count", int'(load_count), m_cnt);
        chk("running", int'(running), int'(m_run));
        chk("prog_ready", int'(prog_ready), int'(!m_run));
        chk("next_instr", int'(next_instr),
            m_run ? int'(m_pm[m_pc]) : 32'hC0);
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic load_n(input int n);
        for (int i = 0; i < n; i++) begin
            prog_valid = 1'b1;
            prog_data  = img[i % 256];
            tick();
        end
        prog_valid = 1'b0;
    endtask

    task automatic run_record(input int n);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        q.delete();
        qi.delete();
        for (int i = 0; i < n; i++) begin
            q.push_back(int'(pc));
            qi.push_back(int'(next_instr));
            tick();
        end
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic expect_after(input string name, input int a,
                                input int e1, input int e2, input int e3);
        int idx;
        idx = -1;
        for (int i = 0; i < q.size(); i++)
            if (idx < 0 && q[i] == a) idx = i;
        if (idx < 0 || idx + 3 >= q.size()) begin
            chk({name, "_found"}, -1, a);
        end else begin
            chk({name, "_1"}, q[idx+1], e1);
            chk({name, "_2"}, q[idx+2], e2);
            chk({name, "_3"}, q[idx+3], e3);
        end
    endtask

    task automatic fill;
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 223));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq5 [5];
        bit hit;
        seq5 = '{8'h05, 8'h12, 8'hE4, 8'hB1, 8'h9A};

        #1 reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_pc", int'(pc), 0);
        chk("rst_ready", int'(prog_ready), 1);
        chk("rst_instr", int'(next_instr), 32'hC0);

        // Reset mid-run
        fill();
        load_n(256);
        chk("wrap256_count", int'(load_count), 0);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (pc == 8'h37) hit = 1'b1;
            else tick();
        end
        chk("reach_37", int'(pc), 32'h37);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_pc", int'(pc), 0);
        chk("arst_running", int'(running), 0);
        chk("arst_ready", int'(prog_ready), 1);
        chk("arst_instr", int'(next_instr), 32'hC0);
        chk("arst_count", int'(load_count), 0);
        tick();
        reset_n = 1'b1;

        // Short program and first fetches
        for (int i = 0; i < 5; i++) img[i] = seq5[i];
        load_n(5);
        chk("load5_count", int'(load_count), 5);
        run_start = 1'b1;
        chk("park_before_run", int'(next_instr), 32'hC0);
        tick();
        run_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("seq5", int'(next_instr), int'(seq5[i]));
            tick();
        end
        load_req = 1'b1;
        tick();
        load_req = 1'b0;

        // Unconditional and conditional jumps
        fill();
        img[8'h12] = 8'hE5;
        img[8'h20] = 8'hF8;
        load_n(256);
        zero_flag = 1'b1;
        run_record(48);
        expect_after("jmp", 32'h12, 32'h13, 32'h15, 32'h16);
        expect_after("jnz_nt", 32'h20, 32'h21, 32'h22, 32'h23);
        zero_flag = 1'b0;
        run_record(48);
        expect_after("jnz_t", 32'h20, 32'h21, 32'h28, 32'h29);

        // Page crossing delay slot, PC wrap, loader wrap
        fill();
        img[8'h1F] = 8'hE2;
        load_n(256);
        prog_valid = 1'b1;
        prog_data  = 8'h3C;
        tick();
        prog_valid = 1'b0;
        chk("wrap257_count", int'(load_count), 1);
        run_record(272);
        chk("wrap257_pm0", qi[0], 32'h3C);
        expect_after("page", 32'h1F, 32'h20, 32'h22, 32'h23);
        expect_after("pcwrap", 32'hFE, 32'hFF, 32'h00, 32'h01);

        // Write accepted in the run_start cycle
        prog_valid = 1'b1;
        prog_data  = 8'h77;
        run_start  = 1'b1;
        tick();
        run_start  = 1'b0;
        chk("rs_wr_running", int'(running), 1);
        chk("rs_wr_instr", int'(next_instr), 32'h77);

        // Loader ignored in RUN
        prog_data = 8'hFF;
        chk("run_ready", int'(prog_ready), 0);
        repeat (4) tick();
        prog_valid = 1'b0;

        // load_req beats a jump
        ovr     = 1'b1;
        ovr_jmp = 1'b1;
        ovr_nib = 4'h5;
        load_req = 1'b1;
        tick();
        ovr      = 1'b0;
        load_req = 1'b0;
        chk("lr_running", int'(running), 0);
        chk("lr_pc", int'(pc), 0);
        chk("lr_instr", int'(next_instr), 32'hC0);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        chk("pm0_kept", int'(next_instr), 32'h77);
        tick();
        chk("pm1_kept", int'(next_instr), int'(img[1]));
        load_req = 1'b1;
        tick();
        load_req = 1'b0;

        // Randomized traffic
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 256; j++) img[j] = 8'($urandom);
            load_n(256);
            run_start = 1'b1;
            tick();
            run_start = 1'b0;
            for (int c = 0; c < 250; c++) begin
                zero_flag  = 1'($urandom_range(0, 1));
                prog_valid = ($urandom_range(0, 1) == 1);
                prog_data  = 8'($urandom);
                run_start  = ($urandom_range(0, 39) == 0);
                load_req   = ($urandom_range(0, 79) == 0);
                if (r == 3 && c == 120) begin
                    @(posedge clk);
                    #2 reset_n = 1'b0;
                    tick();
                    reset_n = 1'b1;
                end
                tick();
            end
            prog_valid = 1'b0;
            run_start  = 1'b0;
            load_req   = 1'b1;
            tick();
            load_req   = 1'b0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
